// File: rtl/branch_pred_unit_pkg.sv
// rtl/branch_pred_unit_pkg.sv - shared types and helpers for the branch prediction unit
// Holds the branch opcode encoding, the 2-bit BHT counter type with its
// reset value, and small pure helpers used by the BHT and resolve logic.
package branch_pred_unit_pkg;

    // Encodings follow the RISC-V funct3 layout; 3'b010 and 3'b011 are not
    // branches and resolve as not-taken without touching any state.
    typedef enum logic [2:0] {
        BR_BEQ  = 3'b000,
        BR_BNE  = 3'b001,
        BR_NOP  = 3'b010,
        BR_RSVD = 3'b011,
        BR_BLT  = 3'b100,
        BR_BGE  = 3'b101,
        BR_BLTU = 3'b110,
        BR_BGEU = 3'b111
    } branch_op_e;

    typedef logic [1:0] bht_cnt_t;

    localparam bht_cnt_t BHT_RESET = 2'b01;
    localparam bht_cnt_t BHT_MAX   = 2'b11;
    localparam bht_cnt_t BHT_MIN   = 2'b00;

    function automatic logic is_branch(input branch_op_e op);
        logic valid;
        valid = 1'b0;
        case (op)
            BR_BEQ, BR_BNE, BR_BLT, BR_BGE, BR_BLTU, BR_BGEU: valid = 1'b1;
            default:                                          valid = 1'b0;
        endcase
        return valid;
    endfunction

    // Saturating 2-bit counter step toward the resolved direction.
    function automatic bht_cnt_t bht_next(input bht_cnt_t cnt, input logic taken);
        bht_cnt_t nxt;
        nxt = cnt;
        if (taken) begin
            if (cnt != BHT_MAX) nxt = cnt + 2'd1;
        end else begin
            if (cnt != BHT_MIN) nxt = cnt - 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/bht_counter_array.sv
// rtl/bht_counter_array.sv - table of 2-bit saturating branch history counters
// Ports:
//   clk_i, rst_ni              clock, asynchronous active-low reset
//   rd_idx_i / rd_cnt_o        combinational read port (pre-edge contents)
//   upd_en_i, upd_idx_i,       single update port; counter moves one step
//   upd_taken_i                toward upd_taken_i on the rising edge
module bht_counter_array
    import branch_pred_unit_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [IDX_W-1:0] rd_idx_i,
    output bht_cnt_t         rd_cnt_o,
    input  logic             upd_en_i,
    input  logic [IDX_W-1:0] upd_idx_i,
    input  logic             upd_taken_i
);

    bht_cnt_t cnt_q [ENTRIES];

    // Reading the registered array directly means a lookup of the index
    // being updated this cycle sees the old counter value.
    assign rd_cnt_o = cnt_q[rd_idx_i];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < ENTRIES; i++) begin
                cnt_q[i] <= BHT_RESET;
            end
        end else if (upd_en_i) begin
            cnt_q[upd_idx_i] <= bht_next(cnt_q[upd_idx_i], upd_taken_i);
        end
    end

endmodule

// File: rtl/branch_pred_unit.sv
// rtl/branch_pred_unit.sv - branch direction predictor and branch resolve unit
// Ports:
//   clk_i, rst_ni                  clock, asynchronous active-low reset
//   pred_pc_i / pred_taken_o       combinational direction lookup for fetch
//   res_valid_i / res_ready_o      resolve request handshake
//   res_op_i, res_pc_i, res_imm_i, branch to resolve: opcode, PC, offset,
//   rs1_data_i, rs2_data_i,        operands, and the direction fetch assumed
//   res_pred_taken_i
//   out_valid_o / out_ready_i      registered resolve result handshake
//   out_taken_o, out_mispredict_o, resolved direction, mispredict flag and
//   out_redirect_pc_o              next PC (target or fall-through)
//   flush_i                        drop in-flight result and current request
//   mispred_cnt_o                  saturating count of mispredicted branches
module branch_pred_unit
    import branch_pred_unit_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int BHT_ENTRIES = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [XLEN-1:0]  pred_pc_i,
    output logic             pred_taken_o,
    input  logic             res_valid_i,
    output logic             res_ready_o,
    input  branch_op_e       res_op_i,
    input  logic [XLEN-1:0]  res_pc_i,
    input  logic [XLEN-1:0]  res_imm_i,
    input  logic [XLEN-1:0]  rs1_data_i,
    input  logic [XLEN-1:0]  rs2_data_i,
    input  logic             res_pred_taken_i,
    output logic             out_valid_o,
    output logic             out_taken_o,
    output logic             out_mispredict_o,
    output logic [XLEN-1:0]  out_redirect_pc_o,
    input  logic             out_ready_i,
    input  logic             flush_i,
    output logic [CNT_W-1:0] mispred_cnt_o
);

    localparam int               IDX     = $clog2(BHT_ENTRIES);
    localparam logic [XLEN-1:0]  PC_STEP = XLEN'(4);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [IDX-1:0]  rd_idx;
    logic [IDX-1:0]  upd_idx;
    bht_cnt_t        rd_cnt;
    logic            accept;
    logic            valid_op;
    logic            eq;
    logic            lt_s;
    logic            lt_u;
    logic            taken;
    logic            mispredict;
    logic [XLEN-1:0] target_pc;
    logic [XLEN-1:0] fall_pc;
    logic            bht_upd;

    // Word-aligned PCs: bits [1:0] carry no index information.
    assign rd_idx  = pred_pc_i[IDX+1:2];
    assign upd_idx = res_pc_i[IDX+1:2];

    logic unused_pc_bits;
    assign unused_pc_bits = ^{pred_pc_i[XLEN-1:IDX+2], pred_pc_i[1:0]};

    assign res_ready_o = !out_valid_o || out_ready_i;
    assign accept      = res_valid_i && res_ready_o && !flush_i;

    assign valid_op = is_branch(res_op_i);
    assign eq       = (rs1_data_i == rs2_data_i);
    assign lt_s     = ($signed(rs1_data_i) < $signed(rs2_data_i));
    assign lt_u     = (rs1_data_i < rs2_data_i);

    always_comb begin
        taken = 1'b0;
        case (res_op_i)
            BR_BEQ:  taken = eq;
            BR_BNE:  taken = !eq;
            BR_BLT:  taken = lt_s;
            BR_BGE:  taken = !lt_s;
            BR_BLTU: taken = lt_u;
            BR_BGEU: taken = !lt_u;
            default: taken = 1'b0;
        endcase
    end

    assign target_pc  = res_pc_i + res_imm_i;
    assign fall_pc    = res_pc_i + PC_STEP;
    assign mispredict = (taken != res_pred_taken_i);
    assign bht_upd    = accept && valid_op;

    bht_counter_array #(
        .ENTRIES (BHT_ENTRIES),
        .IDX_W   (IDX)
    ) u_bht (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .rd_idx_i    (rd_idx),
        .rd_cnt_o    (rd_cnt),
        .upd_en_i    (bht_upd),
        .upd_idx_i   (upd_idx),
        .upd_taken_i (taken)
    );

    assign pred_taken_o = rd_cnt[1];

    // One-entry result register; flush wins over a same-cycle accept.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid_o       <= 1'b0;
            out_taken_o       <= 1'b0;
            out_mispredict_o  <= 1'b0;
            out_redirect_pc_o <= '0;
        end else if (flush_i) begin
            out_valid_o <= 1'b0;
        end else if (accept) begin
            out_valid_o       <= 1'b1;
            out_taken_o       <= taken;
            out_mispredict_o  <= mispredict;
            out_redirect_pc_o <= taken ? target_pc : fall_pc;
        end else if (out_ready_i) begin
            out_valid_o <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mispred_cnt_o <= '0;
        end else if (bht_upd && mispredict && (mispred_cnt_o != CNT_MAX)) begin
            mispred_cnt_o <= mispred_cnt_o + CNT_W'(1);
        end
    end

endmodule

// File: doc/branch_pred_unit.md
BRANCH_PRED_UNIT -- requirements
Module: branch_pred_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath/PC width.
REQ-002 SHALL have parameter BHT_ENTRIES, default 16, number of 2-bit counters; power of 2, >= 2.
REQ-003 SHALL have parameter CNT_W, default 32, mispredict counter width.
REQ-004 SHALL have port clk_i  in  1  clock; all state on rising edge.
REQ-005 SHALL have port rst_ni  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port pred_pc_i  in  XLEN  fetch PC for prediction lookup.
REQ-007 SHALL have port pred_taken_o  out  1  predicted direction for pred_pc_i.
REQ-008 SHALL have port res_valid_i  in  1  resolve request valid.
REQ-009 SHALL have port res_ready_o  out  1  resolve request accepted.
REQ-010 SHALL have ports res_op_i (branch_op_e), res_pc_i (XLEN), res_imm_i (XLEN), rs1_data_i (XLEN), rs2_data_i (XLEN), res_pred_taken_i (1), all in: branch to resolve.
REQ-011 SHALL have ports out_valid_o (1), out_taken_o (1), out_mispredict_o (1), out_redirect_pc_o (XLEN), all out: registered result.
REQ-012 SHALL have port out_ready_i  in  1  consumer accepts result.
REQ-013 SHALL have port flush_i  in  1  discard in-flight result.
REQ-014 SHALL have port mispred_cnt_o  out  CNT_W  saturating mispredict count.

Function
REQ-015 pred_taken_o SHALL be combinational: MSB of counter at index pred_pc_i[$clog2(BHT_ENTRIES)+1:2], reflecting pre-edge state.
REQ-016 Accept SHALL occur when res_valid_i && res_ready_o && !flush_i.
REQ-017 res_ready_o SHALL equal !out_valid_o || out_ready_i (one-entry output register, full throughput).
REQ-018 Taken SHALL be: BEQ eq; BNE !eq; BLT signed lt; BGE !signed lt; BLTU unsigned lt; BGEU !unsigned lt; any other op 0.
REQ-019 Target SHALL be res_pc_i + res_imm_i modulo 2^XLEN; fall-through res_pc_i + 4 modulo 2^XLEN.
REQ-020 On accept, next cycle: out_valid_o=1, out_taken_o=taken, out_redirect_pc_o=taken?target:fall-through, out_mispredict_o=(taken != res_pred_taken_i); latency exactly 1 cycle.
REQ-021 out_valid_o SHALL clear after out_valid_o && out_ready_i with no new accept; output fields hold while out_valid_o && !out_ready_i.
REQ-022 On accept of a valid branch op, counter at index res_pc_i[IDX+1:2] SHALL saturating-increment if taken (max 3), saturating-decrement otherwise (min 0).
REQ-023 Non-branch op SHALL NOT update BHT and SHALL NOT increment mispred_cnt_o.
REQ-024 mispred_cnt_o SHALL increment by 1 on each accept with mispredict of a valid op, saturating at all-ones.
REQ-025 flush_i SHALL clear out_valid_o next cycle and take priority over accept; a request presented during flush_i is dropped with no BHT or counter update.
REQ-026 Same-cycle lookup and update of one index SHALL return the old value on pred_taken_o.

Reset
REQ-027 On rst_ni low, immediately: out_valid_o=0, out_taken_o=0, out_mispredict_o=0, out_redirect_pc_o=0, mispred_cnt_o=0, all BHT counters=2'b01.
REQ-028 Reset mid-transaction SHALL discard any pending result; first accept after deassert SHALL behave as post-reset.

Structure
REQ-029 branch_op_e and the 2-bit counter typedef (bht_cnt_t, constant BHT_RESET=2'b01) SHALL live in the shared core package.
REQ-030 BHT storage and update SHALL be sub-module bht_counter_array (read port + one update port).

Verification
REQ-031 Reset, pred_pc_i=0x40 -> pred_taken_o=0; after two taken BEQ accepts at pc 0x40 -> pred_taken_o=1, counter=3.
REQ-032 BLT rs1=0xFFFFFFFF rs2=1 pc=0x100 imm=0x20 pred=0 -> taken=1, redirect=0x120, mispredict=1, mispred_cnt_o=1; BLTU same operands -> taken=0, redirect=0x104.
REQ-033 out_ready_i=0 with out_valid_o=1 -> res_ready_o=0, outputs stable 5 cycles; raise out_ready_i -> back-to-back results each cycle.
REQ-034 flush_i with res_valid_i=1 -> out_valid_o=0 next cycle, BHT and mispred_cnt_o unchanged.
REQ-035 Taken at pc=0xFFFFFFFC imm=8 -> redirect 0x4; not-taken -> 0x0; invalid op -> taken=0, no BHT update.
REQ-036 rst_ni low mid-stall -> out_valid_o=0 asynchronously, all counters read weakly-not-taken.
